uart_word_tx: RTL and testbench

Serial transmitter stage that consumes the word selected by the tx-source 4:1 multiplexer and drives the UART `tx` line. On a `start` request it latches a LENGTH-bit word and sends it as LENGTH/8 consecutive 8N1 frames, least-significant byte first, with a fixed clock-to-baud divider. It reports `busy` while shifting and pulses `done` when the last stop bit has completed.

---
 rtl/uart_word_tx.sv | 122 ++++++++++++
 tb/tb_uart_word_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// uart_word_tx: sends a LENGTH-bit word as LENGTH/8 back-to-back 8N1 frames, LSB byte first
// Ports:
//   clk   - system clock, all logic on the rising edge
//   rst   - synchronous active-high reset, aborts any word in flight
//   start - transmit request, honoured only while idle
//   data  - word to send, captured when start is accepted
//   tx    - registered UART serial line, idle high
//   busy  - high while a word is being shifted out
//   done  - one-cycle pulse after the final stop bit
module uart_word_tx #(
    parameter int LENGTH   = 32,
    parameter int BAUD_DIV = 434
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LENGTH-1:0] data,
    output logic              tx,
    output logic              busy,
    output logic              done
);
    localparam int BYTES = LENGTH / 8;
    localparam int CW    = $clog2(BAUD_DIV);
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     baud, baud_n;
    logic [2:0]        bit_idx, bit_idx_n;
    logic [BW-1:0]     byte_idx, byte_idx_n;
    logic [LENGTH-1:0] word, word_n, next_word;
    logic [7:0]        shift, shift_n;
    logic              tx_n, busy_n, done_n, tick;

    assign tick      = baud == CW'(BAUD_DIV - 1);
    // The word register drops one byte per frame so the next byte is always in the low bits.
    assign next_word = word >> 8;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            word     <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            baud     <= baud_n;
            bit_idx  <= bit_idx_n;
            byte_idx <= byte_idx_n;
            word     <= word_n;
            shift    <= shift_n;
            tx       <= tx_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // Next-state logic also computes the next value of each registered output,
    // so tx/busy/done change on the same edge as the state they describe.
    always_comb begin
        state_n    = state;
        baud_n     = (state == IDLE || tick) ? '0 : baud + 1'b1;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        word_n     = word;
        shift_n    = shift;
        tx_n       = tx;
        busy_n     = busy;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (start) begin
                    word_n     = data;
                    shift_n    = data[7:0];
                    byte_idx_n = '0;
                    state_n    = START;
                    tx_n       = 1'b0;
                    busy_n     = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                    tx_n      = shift[0];
                end
            end
            DATA: begin
                if (tick) begin
                    state_n   = (bit_idx == 3'd7) ? STOP : DATA;
                    bit_idx_n = bit_idx + 3'd1;
                    tx_n      = (bit_idx == 3'd7) ? 1'b1 : shift[bit_idx + 3'd1];
                end
            end
            STOP: begin
                if (tick) begin
                    if (byte_idx == BW'(BYTES - 1)) begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        byte_idx_n = byte_idx + 1'b1;
                        word_n     = next_word;
                        shift_n    = next_word[7:0];
                        state_n    = START;
                        tx_n       = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: randomized self-checking bench for uart_word_tx (32-bit/div 4 and 8-bit/div 2 instances)
module tb_uart_word_tx;
    localparam int DIV   = 4;
    localparam int NB    = 4;
    localparam int DIV_B = 2;

    logic        clk = 1'b0;
    logic        rst, start, start_b;
    logic [31:0] data;
    logic [7:0]  data_b;
    logic        tx, busy, done, tx_b, busy_b, done_b;
    int          checks = 0;
    int          errors = 0;
    int          disturb_at = 0;

    always #5 clk = ~clk;

    uart_word_tx #(.LENGTH(32), .BAUD_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .start(start), .data(data),
        .tx(tx), .busy(busy), .done(done)
    );

    uart_word_tx #(.LENGTH(8), .BAUD_DIV(DIV_B)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .data(data_b),
        .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    // Line level during cycle c (1-based) after acceptance: frames of 10 bits,
    // start 0, eight data bits LSB first, stop 1, each bit div cycles long.
    function automatic logic expected_tx(input logic [31:0] w, input int div, input int c);
        int idx, pos, k;
        logic [31:0] s;
        idx = (c - 1) / div;
        pos = idx % 10;
        k   = idx / 10;
        s   = w >> (8 * k);
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return s[pos - 1];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller has start=1 and data=w driven; returns while in the done cycle.
    task automatic check_word(input logic [31:0] w);
        step();
        for (int c = 1; c <= NB * 10 * DIV; c++) begin
            checks++;
            if (tx !== expected_tx(w, DIV, c)) begin
                errors++;
                $display("FAIL word_tx w=%h cycle %0d: got %b expected %b", w, c, tx, expected_tx(w, DIV, c));
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL word_busy w=%h cycle %0d: got %b expected 1", w, c, busy);
            end
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL word_done_early w=%h cycle %0d: got %b expected 0", w, c, done);
            end
            start = (c == disturb_at);
            if (c == disturb_at) data = '1;
            step();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL word_done w=%h: got %b expected 1", w, done);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL word_busy_end w=%h: got %b expected 0", w, busy);
        end
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL word_tx_end w=%h: got %b expected 1", w, tx);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({tx, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL %s: got tx/busy/done=%b expected 100", name, {tx, busy, done});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; start_b = 1'b1;
        data = $urandom; data_b = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("reset_a");
            checks++;
            if ({tx_b, busy_b, done_b} !== 3'b100) begin
                errors++;
                $display("FAIL reset_b: got tx/busy/done=%b expected 100", {tx_b, busy_b, done_b});
            end
        end
        rst = 1'b0; start = 1'b0; start_b = 1'b0;
        step();
        check_idle("after_reset_a");
        checks++;
        if ({tx_b, busy_b, done_b} !== 3'b100) begin
            errors++;
            $display("FAIL after_reset_b: got tx/busy/done=%b expected 100", {tx_b, busy_b, done_b});
        end
    endtask

    task automatic test_single_word();
        data = 32'h12345678; start = 1'b1; disturb_at = 0;
        check_word(32'h12345678);
        start = 1'b0;
        step();
        check_idle("single_after_done");
    endtask

    task automatic test_ignored_start();
        logic [31:0] w;
        w = $urandom;
        data = w; start = 1'b1; disturb_at = 50;
        check_word(w);
        disturb_at = 0; start = 1'b0;
        step();
        check_idle("ignored_after_done");
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        w = $urandom;
        data = w; start = 1'b1;
        check_word(w);
        data = 32'hA5A5A5A5; start = 1'b1;
        check_word(32'hA5A5A5A5);
        start = 1'b0;
        step();
        check_idle("b2b_after_done");
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] w;
        w = $urandom;
        data = w; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 37; c++) begin
            checks++;
            if (tx !== expected_tx(w, DIV, c)) begin
                errors++;
                $display("FAIL midrst_tx cycle %0d: got %b expected %b", c, tx, expected_tx(w, DIV, c));
            end
            if (c == 37) rst = 1'b1;
            step();
        end
        check_idle("midrst_cycle38");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check_idle("midrst_no_done");
        end
        w = $urandom;
        data = w; start = 1'b1;
        check_word(w);
        start = 1'b0;
        step();
        check_idle("midrst_new_word_end");
    endtask

    task automatic test_random_words();
        logic [31:0] w;
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            data = w; start = 1'b1;
            check_word(w);
            start = 1'b0;
            repeat ($urandom_range(1, 4)) step();
            check_idle("random_idle");
        end
    endtask

    task automatic test_corner();
        logic [7:0] b;
        for (int r = 0; r < 2; r++) begin
            b = (r == 0) ? 8'h00 : 8'($urandom);
            data_b = b; start_b = 1'b1;
            step();
            start_b = 1'b0;
            for (int c = 1; c <= 10 * DIV_B; c++) begin
                checks++;
                if (tx_b !== expected_tx({24'h0, b}, DIV_B, c)) begin
                    errors++;
                    $display("FAIL corner_tx b=%h cycle %0d: got %b expected %b", b, c, tx_b, expected_tx({24'h0, b}, DIV_B, c));
                end
                checks++;
                if ({busy_b, done_b} !== 2'b10) begin
                    errors++;
                    $display("FAIL corner_busy b=%h cycle %0d: got busy/done=%b expected 10", b, c, {busy_b, done_b});
                end
                step();
            end
            checks++;
            if ({tx_b, busy_b, done_b} !== 3'b101) begin
                errors++;
                $display("FAIL corner_done b=%h: got tx/busy/done=%b expected 101", b, {tx_b, busy_b, done_b});
            end
            step();
            checks++;
            if ({tx_b, busy_b, done_b} !== 3'b100) begin
                errors++;
                $display("FAIL corner_idle b=%h: got tx/busy/done=%b expected 100", b, {tx_b, busy_b, done_b});
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_b = 1'b0; data = '0; data_b = '0;
        test_reset();
        test_single_word();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_words();
        test_corner();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
